fp_add_arbiter: RTL and testbench

//  Round-robin arbiter that shares one external single-precision FP adder among NUM_REQ requesters.

---
 rtl/fp_add_arbiter_if.sv | 35 +++
 rtl/fp_add_arbiter.sv | 174 +++++++++++++++++
 tb/tb_fp_add_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_arbiter_if.sv
// Bus bundle between the FP-adder arbiter, its requesters and the shared adder.
// Ports carried: req_valid/req_ready/req_a/req_b (operand handshake),
// rsp_valid/rsp_z (results), add_a/add_b/add_valid/add_z (adder side),
// pause/idle (drain control) and issue_count (accepted-request counter).
// slave = arbiter view, master = requester/adder/environment view.
interface fp_add_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_z;
    logic [DATA_W-1:0]         add_a;
    logic [DATA_W-1:0]         add_b;
    logic                      add_valid;
    logic [DATA_W-1:0]         add_z;
    logic                      pause;
    logic                      idle;
    logic [CNT_W-1:0]          issue_count;

    modport slave (
        input  req_valid, req_a, req_b, add_z, pause,
        output req_ready, rsp_valid, rsp_z, add_a, add_b, add_valid, idle, issue_count
    );

    modport master (
        output req_valid, req_a, req_b, add_z, pause,
        input  req_ready, rsp_valid, rsp_z, add_a, add_b, add_valid, idle, issue_count
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-precision FP adder among
// NUM_REQ requesters. Accepted operand pairs are registered onto the adder, a
// tag pipe carries each requester ID alongside the operation, and the sum is
// returned to its requester as a one-cycle rsp_valid pulse.
// Ports: clock, reset_n (async, active-low), bus (fp_add_arbiter_if.slave):
//   req_valid/req_ready/req_a/req_b, rsp_valid/rsp_z, add_a/add_b/add_valid/add_z,
//   pause/idle, issue_count.
module fp_add_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADD_LATENCY = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    fp_add_arbiter_if.slave bus
);
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned ID_W       = 3;
    localparam int unsigned TAG_STAGES = ADD_LATENCY + 1;

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, PAUSED = 2'd2} state_e;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    state_e                     state_q, state_d;
    logic [ID_W-1:0]            ptr_q, ptr_d;
    tag_t [TAG_STAGES-1:0]      tag_q, tag_d;
    logic [DATA_W-1:0]          add_a_q, add_a_d;
    logic [DATA_W-1:0]          add_b_q, add_b_d;
    logic                       add_valid_q, add_valid_d;
    logic [DATA_W-1:0]          rsp_z_q, rsp_z_d;
    logic [NUM_REQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic                       idle_q, idle_d;
    logic [CNT_W-1:0]           issue_count_q, issue_count_d;

    logic                       pipe_busy;
    logic                       grant_vld;
    logic [ID_W-1:0]            grant_id;
    logic [ID_W-1:0]            scan_id;
    logic                       issue_en;
    logic                       fire;
    logic [DATA_W-1:0]          sel_a;
    logic [DATA_W-1:0]          sel_b;
    logic                       busy_next;

    // Anything still travelling through the adder.
    always_comb begin
        pipe_busy = add_valid_q;
        for (int unsigned i = 0; i < TAG_STAGES; i++) begin
            pipe_busy = pipe_busy | tag_q[i].vld;
        end
    end

    // Pause/drain state machine.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (bus.pause) state_d = DRAIN;
            DRAIN:   if (!bus.pause) state_d = RUN;
                     else if (!pipe_busy) state_d = PAUSED;
            PAUSED:  if (!bus.pause) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Round-robin search starting at ptr; first valid requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_id   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_id = ID_W'((32'(ptr_q) + k) % NUM_REQ);
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!grant_vld && scan_id == ID_W'(i) && bus.req_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_id  = scan_id;
                end
            end
        end
    end

    // Accept only in cycles that end in RUN: a falling pause re-enters RUN from
    // any state, so accepts resume in that same cycle; a rising pause blocks at once.
    assign issue_en = !bus.pause && (state_d == RUN);
    assign fire     = issue_en && grant_vld;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = fire && (grant_id == ID_W'(i));
            if (grant_id == ID_W'(i)) begin
                sel_a = bus.req_a[i*DATA_W +: DATA_W];
                sel_b = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // Issue, tag pipe, response capture and idle.
    always_comb begin
        add_a_d       = add_a_q;
        add_b_d       = add_b_q;
        add_valid_d   = 1'b0;
        ptr_d         = ptr_q;
        issue_count_d = issue_count_q;
        rsp_z_d       = rsp_z_q;
        rsp_valid_d   = '0;

        if (fire) begin
            add_a_d       = sel_a;
            add_b_d       = sel_b;
            add_valid_d   = 1'b1;
            ptr_d         = ID_W'((32'(grant_id) + 1) % NUM_REQ);
            issue_count_d = issue_count_q + 1'b1;
        end

        // Stage 0 launches with the operands; the last stage lines up with add_z.
        tag_d[0].vld = fire;
        tag_d[0].id  = fire ? grant_id : '0;
        for (int unsigned i = 1; i < TAG_STAGES; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        if (tag_q[TAG_STAGES-1].vld) begin
            rsp_z_d = bus.add_z;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                rsp_valid_d[i] = (tag_q[TAG_STAGES-1].id == ID_W'(i));
            end
        end

        busy_next = add_valid_d;
        for (int unsigned i = 0; i < TAG_STAGES; i++) begin
            busy_next = busy_next | tag_d[i].vld;
        end
        idle_d = !busy_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            ptr_q         <= '0;
            tag_q         <= '0;
            add_a_q       <= '0;
            add_b_q       <= '0;
            add_valid_q   <= 1'b0;
            rsp_z_q       <= '0;
            rsp_valid_q   <= '0;
            idle_q        <= 1'b1;
            issue_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            tag_q         <= tag_d;
            add_a_q       <= add_a_d;
            add_b_q       <= add_b_d;
            add_valid_q   <= add_valid_d;
            rsp_z_q       <= rsp_z_d;
            rsp_valid_q   <= rsp_valid_d;
            idle_q        <= idle_d;
            issue_count_q <= issue_count_d;
        end
    end

    assign bus.add_a       = add_a_q;
    assign bus.add_b       = add_b_q;
    assign bus.add_valid   = add_valid_q;
    assign bus.rsp_z       = rsp_z_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.idle        = idle_q;
    assign bus.issue_count = issue_count_q;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter (NUM_REQ=4, ADD_LATENCY=4) with a
// fixed-latency single-precision adder model and a response log.
module tb_fp_add_arbiter;
    localparam int unsigned NR  = 4;
    localparam int unsigned LAT = 4;

    localparam logic [31:0] F1 = 32'h3F80_0000;
    localparam logic [31:0] F2 = 32'h4000_0000;
    localparam logic [31:0] F3 = 32'h4040_0000;
    localparam logic [31:0] F4 = 32'h4080_0000;
    localparam logic [31:0] F5 = 32'h40A0_0000;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    fp_add_arbiter_if #(.NUM_REQ(NR)) bus ();

    fp_add_arbiter #(.NUM_REQ(NR), .ADD_LATENCY(LAT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Single-precision <-> double via bit fields; exact for the small normals used here.
    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == 31'd0) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    // Adder model: sum appears on add_z LAT cycles after add_valid, poison otherwise.
    logic [31:0] pz [LAT];
    logic        pv [LAT];
    always @(posedge clock) begin
        pz[0] <= r2sp(sp2r(bus.add_a) + sp2r(bus.add_b));
        pv[0] <= bus.add_valid;
        for (int i = 1; i < LAT; i++) begin
            pz[i] <= pz[i-1];
            pv[i] <= pv[i-1];
        end
    end
    assign bus.add_z = pv[LAT-1] ? pz[LAT-1] : 32'hDEAD_BEEF;

    // Cycle counter and response log.
    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic                log_en = 1'b1;
    logic [NR-1:0]       log_rv [$];
    logic [31:0]         log_z  [$];
    int unsigned         log_c  [$];
    always @(negedge clock) begin
        if (log_en && bus.rsp_valid != '0) begin
            log_rv.push_back(bus.rsp_valid);
            log_z.push_back(bus.rsp_z);
            log_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_log();
        log_rv.delete();
        log_z.delete();
        log_c.delete();
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_req_ready"},   32'(bus.req_ready),   32'h0);
        chk({pfx, "_rsp_valid"},   32'(bus.rsp_valid),   32'h0);
        chk({pfx, "_rsp_z"},       bus.rsp_z,            32'h0);
        chk({pfx, "_add_a"},       bus.add_a,            32'h0);
        chk({pfx, "_add_b"},       bus.add_b,            32'h0);
        chk({pfx, "_add_valid"},   32'(bus.add_valid),   32'h0);
        chk({pfx, "_idle"},        32'(bus.idle),        32'h1);
        chk({pfx, "_issue_count"}, 32'(bus.issue_count), 32'h0);
    endtask

    logic [31:0] exp_z [NR];
    int unsigned c0;

    initial begin
        exp_z[0] = F2; exp_z[1] = F3; exp_z[2] = F4; exp_z[3] = F5;
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.pause     = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        chk_reset_vals("reset");
        reset_n = 1'b1;
        tick();

        // 1: single request from req0, 1.0 + 2.0.
        set_ops(0, F1, F2);
        bus.req_valid = 4'b0001;
        #1 chk("t1_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        chk("t1_add_valid", 32'(bus.add_valid), 32'h1);
        chk("t1_add_a", bus.add_a, F1);
        chk("t1_add_b", bus.add_b, F2);
        chk("t1_count", 32'(bus.issue_count), 32'd1);
        chk("t1_idle_busy", 32'(bus.idle), 32'h0);
        repeat (4) tick();
        chk("t1_rsp_early", 32'(bus.rsp_valid), 32'h0);
        tick();
        chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("t1_rsp_z", bus.rsp_z, F3);
        tick();
        chk("t1_rsp_pulse", 32'(bus.rsp_valid), 32'h0);
        chk("t1_rsp_hold", bus.rsp_z, F3);
        repeat (3) tick();
        chk("t1_idle", 32'(bus.idle), 32'h1);
        chk("t1_add_a_hold", bus.add_a, F1);

        // Bring ptr back to 0 through req3 (pointer 3 -> 0 wrap).
        set_ops(3, F4, F1);
        bus.req_valid = 4'b1000;
        #1 chk("wrap_ready", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = '0;
        repeat (8) tick();
        clear_log();

        // 2: all four valid for 8 cycles from ptr=0.
        for (int i = 0; i < 4; i++) set_ops(i, r2sp(real'(i + 1)), F1);
        bus.req_valid = 4'b1111;
        #1;
        c0 = cyc;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t2_ready_%0d", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
            tick();
        end
        bus.req_valid = '0;
        repeat (8) tick();
        chk("t2_rsp_cnt", 32'(log_rv.size()), 32'd8);
        for (int k = 0; k < 8 && k < log_rv.size(); k++) begin
            chk($sformatf("t2_rsp_id_%0d", k), 32'(log_rv[k]), 32'(1 << (k % 4)));
            chk($sformatf("t2_rsp_z_%0d", k), log_z[k], exp_z[k % 4]);
            chk($sformatf("t2_rsp_cyc_%0d", k), log_c[k], c0 + 32'(k) + 32'd6);
        end
        clear_log();

        // 3: only req2 valid for 5 cycles.
        bus.req_valid = 4'b0100;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_ready_%0d", k), 32'(bus.req_ready), 32'h4);
            tick();
        end
        bus.req_valid = '0;
        repeat (8) tick();
        chk("t3_rsp_cnt", 32'(log_rv.size()), 32'd5);
        for (int k = 0; k < 5 && k < log_rv.size(); k++) begin
            chk($sformatf("t3_rsp_id_%0d", k), 32'(log_rv[k]), 32'h4);
            chk($sformatf("t3_rsp_z_%0d", k), log_z[k], F4);
            chk($sformatf("t3_rsp_gap_%0d", k), log_c[k] - log_c[0], 32'(k));
        end
        chk("t3_count", 32'(bus.issue_count), 32'd15);
        clear_log();

        // 4: three issues, then pause with valid still high, drain, resume.
        bus.req_valid = 4'b0001;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t4_ready_%0d", k), 32'(bus.req_ready), 32'h1);
            tick();
        end
        bus.pause = 1'b1;
        #1 chk("t4_pause_block", 32'(bus.req_ready), 32'h0);
        repeat (10) tick();
        chk("t4_paused_ready", 32'(bus.req_ready), 32'h0);
        chk("t4_idle", 32'(bus.idle), 32'h1);
        chk("t4_add_valid", 32'(bus.add_valid), 32'h0);
        chk("t4_rsp_cnt", 32'(log_rv.size()), 32'd3);
        chk("t4_count", 32'(bus.issue_count), 32'd18);
        bus.pause = 1'b0;
        #1 chk("t4_resume_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        chk("t4_resume_issue", 32'(bus.add_valid), 32'h1);
        chk("t4_resume_count", 32'(bus.issue_count), 32'd19);
        repeat (8) tick();
        clear_log();

        // 5: reset with two operations in flight.
        bus.req_valid = 4'b0010;
        tick();
        tick();
        bus.req_valid = '0;
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("t5");
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk("t5_no_rsp", 32'(log_rv.size()), 32'd0);
        chk("t5_count", 32'(bus.issue_count), 32'd0);

        // 6: issue_count wrap after 65535 accepts.
        log_en = 1'b0;
        bus.req_valid = 4'b0001;
        repeat (65535) @(posedge clock);
        #2;
        chk("t6_count_max", 32'(bus.issue_count), 32'h0000_FFFF);
        tick();
        chk("t6_count_wrap", 32'(bus.issue_count), 32'h0);
        bus.req_valid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
